// File: rtl/regfile_access_ctrl.sv
// Register-bank initiator: decode, operand fetch, issue, writeback and debug dump.
// One instruction in flight; $0 is never written because a zero destination skips writeback.
module regfile_access_ctrl #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [31:0]       instr,
  output logic [ADDR_W-1:0] rf_read_reg1,
  output logic [ADDR_W-1:0] rf_read_reg2,
  input  logic [DATA_W-1:0] rf_data1,
  input  logic [DATA_W-1:0] rf_data2,
  output logic              rf_write_en,
  output logic [ADDR_W-1:0] rf_write_reg,
  output logic [DATA_W-1:0] rf_write_data,
  output logic              op_valid,
  input  logic              op_ready,
  output logic [DATA_W-1:0] op_a,
  output logic [DATA_W-1:0] op_b,
  output logic [ADDR_W-1:0] op_dest,
  input  logic              wb_valid,
  output logic              wb_ready,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              dump_start,
  output logic              dump_valid,
  output logic [ADDR_W-1:0] dump_index,
  output logic [DATA_W-1:0] dump_data
);

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_ISSUE, S_WAIT_WB, S_WRITE, S_DUMP
  } state_t;

  state_t              state_q, state_d;
  logic [31:0]         instr_q, instr_d;
  logic [DATA_W-1:0]   op_a_q, op_a_d;
  logic [DATA_W-1:0]   op_b_q, op_b_d;
  logic [ADDR_W-1:0]   op_dest_q, op_dest_d;
  logic [DATA_W-1:0]   wb_data_q, wb_data_d;
  logic [ADDR_W-1:0]   dump_cnt_q, dump_cnt_d;
  logic                idle_rdy;

  // Returns 0 when the instruction has no architectural destination.
  function automatic logic [4:0] dest_of(input logic [31:0] w);
    logic [4:0] d;
    d = 5'd0;
    case (w[31:26])
      6'h00:                       d = (w[5:0] == 6'h08) ? 5'd0 : w[15:11];
      6'h08, 6'h09, 6'h0A, 6'h0B,
      6'h0C, 6'h0D, 6'h0E, 6'h0F,
      6'h23:                       d = w[20:16];
      6'h03:                       d = 5'd31;
      default:                     d = 5'd0;
    endcase
    return d;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      instr_q    <= '0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      op_dest_q  <= '0;
      wb_data_q  <= '0;
      dump_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      instr_q    <= instr_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      op_dest_q  <= op_dest_d;
      wb_data_q  <= wb_data_d;
      dump_cnt_q <= dump_cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    instr_d       = instr_q;
    op_a_d        = op_a_q;
    op_b_d        = op_b_q;
    op_dest_d     = op_dest_q;
    wb_data_d     = wb_data_q;
    dump_cnt_d    = dump_cnt_q;
    idle_rdy      = 1'b0;
    rf_read_reg1  = '0;
    rf_read_reg2  = '0;
    rf_write_en   = 1'b0;
    rf_write_reg  = '0;
    rf_write_data = '0;
    op_valid      = 1'b0;
    wb_ready      = 1'b0;
    dump_valid    = 1'b0;
    dump_index    = '0;
    dump_data     = '0;

    case (state_q)
      S_IDLE: begin
        idle_rdy = 1'b1;
        if (dump_start) begin
          dump_cnt_d = '0;
          state_d    = S_DUMP;
        end else if (instr_valid) begin
          instr_d = instr;
          state_d = S_READ;
        end
      end
      S_READ: begin
        rf_read_reg1 = ADDR_W'(instr_q[25:21]);
        rf_read_reg2 = ADDR_W'(instr_q[20:16]);
        op_a_d       = rf_data1;
        op_b_d       = rf_data2;
        op_dest_d    = ADDR_W'(dest_of(instr_q));
        state_d      = S_ISSUE;
      end
      S_ISSUE: begin
        op_valid = 1'b1;
        if (op_ready) state_d = (op_dest_q != '0) ? S_WAIT_WB : S_IDLE;
      end
      S_WAIT_WB: begin
        wb_ready = 1'b1;
        if (wb_valid) begin
          wb_data_d = wb_data;
          state_d   = S_WRITE;
        end
      end
      S_WRITE: begin
        rf_write_en   = (op_dest_q != '0);
        rf_write_reg  = op_dest_q;
        rf_write_data = wb_data_q;
        state_d       = S_IDLE;
      end
      S_DUMP: begin
        rf_read_reg1 = dump_cnt_q;
        dump_valid   = 1'b1;
        dump_index   = dump_cnt_q;
        dump_data    = rf_data1;
        if (dump_cnt_q == ADDR_W'(NUM_REGS - 1)) begin
          dump_cnt_d = '0;
          state_d    = S_IDLE;
        end else begin
          dump_cnt_d = dump_cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Held low while reset is asserted so every output reads 0 during reset.
  assign instr_ready = idle_rdy & ~reset;
  assign op_a        = op_a_q;
  assign op_b        = op_b_q;
  assign op_dest     = op_dest_q;

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Directed bench for regfile_access_ctrl with a behavioural register bank.
module tb_regfile_access_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [31:0] instr = '0;
  logic [4:0]  rf_read_reg1, rf_read_reg2;
  logic [31:0] rf_data1, rf_data2;
  logic        rf_write_en;
  logic [4:0]  rf_write_reg;
  logic [31:0] rf_write_data;
  logic        op_valid;
  logic        op_ready = 1'b1;
  logic [31:0] op_a, op_b;
  logic [4:0]  op_dest;
  logic        wb_valid = 1'b0;
  logic        wb_ready;
  logic [31:0] wb_data = '0;
  logic        dump_start = 1'b0;
  logic        dump_valid;
  logic [4:0]  dump_index;
  logic [31:0] dump_data;

  logic [31:0] bank [32];
  int          vectors = 0;
  int          miscompares = 0;
  int          wr_count = 0;

  assign rf_data1 = bank[rf_read_reg1];
  assign rf_data2 = bank[rf_read_reg2];

  regfile_access_ctrl #(.NUM_REGS(32), .ADDR_W(5), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .rf_read_reg1(rf_read_reg1), .rf_read_reg2(rf_read_reg2),
    .rf_data1(rf_data1), .rf_data2(rf_data2),
    .rf_write_en(rf_write_en), .rf_write_reg(rf_write_reg), .rf_write_data(rf_write_data),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b), .op_dest(op_dest),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data),
    .dump_start(dump_start), .dump_valid(dump_valid),
    .dump_index(dump_index), .dump_data(dump_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (rf_write_en) wr_count++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 32; i++) bank[i] = '0;
    reset = 1'b1;
    tick();
    tick();
    vectors++;
    if ({instr_ready, rf_read_reg1, rf_read_reg2, rf_write_en, rf_write_reg, rf_write_data,
         op_valid, op_a, op_b, op_dest, wb_ready, dump_valid, dump_index, dump_data} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: instr_ready=%b op_valid=%b wb_ready=%b dump_valid=%b, required all 0",
               instr_ready, op_valid, wb_ready, dump_valid);
    end
    reset = 1'b0;
    tick();
    vectors++;
    if (instr_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_release_ready: got %b want 1", instr_ready);
    end
  endtask

  task automatic test_addi();
    op_ready = 1'b1;
    instr = 32'h2008_0005;
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    vectors++;
    if ({instr_ready, rf_read_reg1, rf_read_reg2, op_valid} !== {1'b0, 5'd0, 5'd8, 1'b0}) begin
      miscompares++;
      $display("FAIL addi_read: rdy=%b r1=%0d r2=%0d opv=%b want 0/0/8/0",
               instr_ready, rf_read_reg1, rf_read_reg2, op_valid);
    end
    tick();
    vectors++;
    if ({op_valid, op_dest, op_a} !== {1'b1, 5'd8, 32'd0}) begin
      miscompares++;
      $display("FAIL addi_issue: opv=%b dest=%0d a=%0d want 1/8/0", op_valid, op_dest, op_a);
    end
    tick();
    vectors++;
    if ({wb_ready, op_valid} !== 2'b10) begin
      miscompares++;
      $display("FAIL addi_wait_wb: wb_ready=%b op_valid=%b want 1/0", wb_ready, op_valid);
    end
    wb_valid = 1'b1;
    wb_data = 32'd5;
    tick();
    wb_valid = 1'b0;
    vectors++;
    if ({rf_write_en, rf_write_reg, rf_write_data} !== {1'b1, 5'd8, 32'd5}) begin
      miscompares++;
      $display("FAIL addi_write: en=%b reg=%0d data=%0d want 1/8/5", rf_write_en, rf_write_reg, rf_write_data);
    end
    tick();
    vectors++;
    if ({instr_ready, rf_write_en, wb_ready} !== 3'b100) begin
      miscompares++;
      $display("FAIL addi_idle: rdy=%b we=%b wbr=%b want 1/0/0", instr_ready, rf_write_en, wb_ready);
    end
  endtask

  task automatic test_stall();
    bank[1] = 32'd7;
    bank[2] = 32'd9;
    op_ready = 1'b0;
    instr = 32'h0022_1820;
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    vectors++;
    if ({rf_read_reg1, rf_read_reg2} !== {5'd1, 5'd2}) begin
      miscompares++;
      $display("FAIL add_read_addr: r1=%0d r2=%0d want 1/2", rf_read_reg1, rf_read_reg2);
    end
    tick();
    for (int c = 0; c < 5; c++) begin
      vectors++;
      if ({op_valid, op_a, op_b, op_dest} !== {1'b1, 32'd7, 32'd9, 5'd3}) begin
        miscompares++;
        $display("FAIL add_stall_c%0d: opv=%b a=%0d b=%0d dest=%0d want 1/7/9/3",
                 c, op_valid, op_a, op_b, op_dest);
      end
      if (c < 4) tick();
    end
    op_ready = 1'b1;
    tick();
    tick();
    vectors++;
    if ({wb_ready, op_valid, op_a, op_dest} !== {1'b1, 1'b0, 32'd7, 5'd3}) begin
      miscompares++;
      $display("FAIL add_wb_hold: wbr=%b opv=%b a=%0d dest=%0d want 1/0/7/3", wb_ready, op_valid, op_a, op_dest);
    end
    wb_valid = 1'b1;
    wb_data = 32'd16;
    tick();
    wb_valid = 1'b0;
    vectors++;
    if ({rf_write_en, rf_write_reg, rf_write_data} !== {1'b1, 5'd3, 32'd16}) begin
      miscompares++;
      $display("FAIL add_write: en=%b reg=%0d data=%0d want 1/3/16", rf_write_en, rf_write_reg, rf_write_data);
    end
    tick();
  endtask

  task automatic test_no_dest();
    logic [31:0] words [3];
    int          w0;
    words[0] = 32'hAC22_0000;
    words[1] = 32'h2000_0001;
    words[2] = 32'h03E0_0008;
    w0 = wr_count;
    op_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      instr = words[k];
      instr_valid = 1'b1;
      tick();
      instr_valid = 1'b0;
      tick();
      vectors++;
      if ({op_valid, op_dest, wb_ready} !== {1'b1, 5'd0, 1'b0}) begin
        miscompares++;
        $display("FAIL nodest_issue_%08h: opv=%b dest=%0d wbr=%b want 1/0/0", words[k], op_valid, op_dest, wb_ready);
      end
      tick();
      vectors++;
      if ({instr_ready, wb_ready, rf_write_en} !== 3'b100) begin
        miscompares++;
        $display("FAIL nodest_idle_%08h: rdy=%b wbr=%b we=%b want 1/0/0", words[k], instr_ready, wb_ready, rf_write_en);
      end
    end
    vectors++;
    if (wr_count !== w0) begin
      miscompares++;
      $display("FAIL nodest_writes: got %0d bank writes want 0", wr_count - w0);
    end
  endtask

  task automatic test_jal();
    instr = 32'h0C00_0000;
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    tick();
    vectors++;
    if ({op_valid, op_dest} !== {1'b1, 5'd31}) begin
      miscompares++;
      $display("FAIL jal_dest: opv=%b dest=%0d want 1/31", op_valid, op_dest);
    end
    tick();
    wb_valid = 1'b1;
    wb_data = 32'h0000_1234;
    tick();
    wb_valid = 1'b0;
    vectors++;
    if ({rf_write_en, rf_write_reg, rf_write_data} !== {1'b1, 5'd31, 32'h1234}) begin
      miscompares++;
      $display("FAIL jal_write: en=%b reg=%0d data=%h want 1/31/1234", rf_write_en, rf_write_reg, rf_write_data);
    end
    tick();
  endtask

  task automatic test_dump();
    for (int i = 0; i < 32; i++) bank[i] = 32'(i * 3);
    dump_start = 1'b1;
    tick();
    for (int i = 0; i < 32; i++) begin
      vectors++;
      if ({dump_valid, dump_index, dump_data, instr_ready} !== {1'b1, 5'(i), 32'(i * 3), 1'b0}) begin
        miscompares++;
        $display("FAIL dump_%0d: v=%b idx=%0d data=%0d rdy=%b want 1/%0d/%0d/0",
                 i, dump_valid, dump_index, dump_data, instr_ready, i, i * 3);
      end
      if (i == 3) dump_start = 1'b0;
      tick();
    end
    vectors++;
    if ({dump_valid, instr_ready} !== 2'b01) begin
      miscompares++;
      $display("FAIL dump_end: v=%b rdy=%b want 0/1", dump_valid, instr_ready);
    end
  endtask

  task automatic test_back_to_back();
    dump_start = 1'b1;
    instr = 32'h3405_0003;
    instr_valid = 1'b1;
    tick();
    dump_start = 1'b0;
    for (int i = 0; i < 32; i++) begin
      vectors++;
      if ({dump_valid, dump_index, instr_ready, rf_read_reg2} !== {1'b1, 5'(i), 1'b0, 5'd0}) begin
        miscompares++;
        $display("FAIL collide_dump_%0d: v=%b idx=%0d rdy=%b r2=%0d want 1/%0d/0/0",
                 i, dump_valid, dump_index, instr_ready, rf_read_reg2, i);
      end
      tick();
    end
    vectors++;
    if ({instr_ready, dump_valid} !== 2'b10) begin
      miscompares++;
      $display("FAIL collide_idle: rdy=%b v=%b want 1/0", instr_ready, dump_valid);
    end
    tick();
    instr_valid = 1'b0;
    vectors++;
    if ({rf_read_reg1, rf_read_reg2} !== {5'd0, 5'd5}) begin
      miscompares++;
      $display("FAIL collide_read: r1=%0d r2=%0d want 0/5", rf_read_reg1, rf_read_reg2);
    end
    tick();
    vectors++;
    if ({op_valid, op_dest, op_b} !== {1'b1, 5'd5, 32'd15}) begin
      miscompares++;
      $display("FAIL collide_issue: opv=%b dest=%0d b=%0d want 1/5/15", op_valid, op_dest, op_b);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int w0;
    w0 = wr_count;
    vectors++;
    if (wb_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL rstmid_pre: wb_ready=%b want 1", wb_ready);
    end
    wb_valid = 1'b1;
    wb_data = 32'hDEAD_BEEF;
    reset = 1'b1;
    #1;
    vectors++;
    if ({instr_ready, rf_write_en, op_valid, op_a, op_b, op_dest, wb_ready, dump_valid} !== '0) begin
      miscompares++;
      $display("FAIL rstmid_outputs: rdy=%b we=%b wbr=%b dest=%0d b=%0d want all 0",
               instr_ready, rf_write_en, wb_ready, op_dest, op_b);
    end
    tick();
    reset = 1'b0;
    wb_valid = 1'b0;
    tick();
    vectors++;
    if ({instr_ready, rf_write_en, wb_ready} !== 3'b100 || wr_count !== w0) begin
      miscompares++;
      $display("FAIL rstmid_after: rdy=%b we=%b wbr=%b writes=%0d want 1/0/0/0",
               instr_ready, rf_write_en, wb_ready, wr_count - w0);
    end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_stall();
    test_no_dest();
    test_jal();
    test_dump();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
